// File: rtl/mc14500_pkg.sv
// MC14500 shared definitions: ICU opcodes and sequencer state.
// Used by the ICU, the sequencer and the benches.
package mc14500_pkg;

  localparam logic [3:0] NOPO = 4'h0;
  localparam logic [3:0] LD   = 4'h1;
  localparam logic [3:0] LDC  = 4'h2;
  localparam logic [3:0] AND  = 4'h3;
  localparam logic [3:0] ANDC = 4'h4;
  localparam logic [3:0] OR   = 4'h5;
  localparam logic [3:0] ORC  = 4'h6;
  localparam logic [3:0] XNOR = 4'h7;
  localparam logic [3:0] STO  = 4'h8;
  localparam logic [3:0] STOC = 4'h9;
  localparam logic [3:0] IEN  = 4'hA;
  localparam logic [3:0] OEN  = 4'hB;
  localparam logic [3:0] JMP  = 4'hC;
  localparam logic [3:0] RTN  = 4'hD;
  localparam logic [3:0] SKZ  = 4'hE;
  localparam logic [3:0] NOPF = 4'hF;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mc14500_seq_if.sv
// Sequencer <-> program memory / ICU bundle.
// master = sequencer, slave = memory + ICU side.
interface mc14500_seq_if #(
  parameter int AW   = 8,
  parameter int IOAW = 3
);
  logic [AW-1:0]   prog_addr;
  logic [AW+3:0]   prog_data;
  logic [3:0]      i;
  logic [IOAW-1:0] io_addr;
  logic            jmp;
  logic            rtn;
  logic            flg0;
  logic            flgf;

  modport master (
    output prog_addr, i, io_addr,
    input  prog_data, jmp, rtn, flg0, flgf
  );

  modport slave (
    input  prog_addr, i, io_addr,
    output prog_data, jmp, rtn, flg0, flgf
  );
endinterface

// File: rtl/mc14500_stack.sv
// Return-address LIFO for the MC14500 sequencer.
// push and pop are never asserted together.
module mc14500_stack
  import mc14500_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_din,
  output logic [AW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_rd_idx;

  assign w_wr_idx = IW'(r_sp);
  assign w_rd_idx = IW'(r_sp - SPW'(1));
  assign o_dout   = r_mem[w_rd_idx];
  assign o_full   = (r_sp == SPW'(DEPTH));
  assign o_empty  = (r_sp == '0);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sp <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (i_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end
endmodule

// File: rtl/mc14500_seq.sv
// MC14500 program sequencer: owns the PC, fetches one word per
// cycle and handles jump, call/return and halt from ICU flags.
module mc14500_seq
  import mc14500_pkg::*;
#(
  parameter int AW    = 8,
  parameter int IOAW  = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  mc14500_seq_if.master bus,
  output logic          halted,
  output logic          err
);
  seq_state_e    r_state;
  logic [AW-1:0] r_pc;
  logic          r_err;
  logic          r_halted;

  logic          w_run_st;
  logic [3:0]    w_op;
  logic [AW-1:0] w_opnd;
  logic [AW-1:0] w_ret;
  logic [AW-1:0] w_dout;
  logic          w_full;
  logic          w_empty;
  logic          w_do_jmp;
  logic          w_do_rtn;
  logic          w_do_call;
  logic          w_do_stop;
  logic          w_push;
  logic          w_pop;
  logic          w_clr;

  assign w_run_st = (r_state == RUN);
  assign w_op     = bus.prog_data[AW+3:AW];
  assign w_opnd   = bus.prog_data[AW-1:0];
  assign w_ret    = r_pc + AW'(1);

  assign bus.prog_addr = r_pc;
  assign bus.i         = w_run_st ? w_op : NOPO;
  assign bus.io_addr   = w_run_st ? w_opnd[IOAW-1:0] : '0;

  // Mutually exclusive one-hot of the next-PC priority chain
  assign w_do_jmp  = bus.jmp;
  assign w_do_rtn  = !bus.jmp && bus.rtn;
  assign w_do_call = !bus.jmp && !bus.rtn
                   && bus.flg0 && (w_opnd != '0);
  assign w_do_stop = !bus.jmp && !bus.rtn && !w_do_call
                   && bus.flgf && (&w_opnd);

  assign w_push = w_run_st && w_do_call && !w_full;
  assign w_pop  = w_run_st && w_do_rtn && !w_empty;
  assign w_clr  = !w_run_st && run;

  mc14500_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_ret),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HALT;
      r_pc     <= '0;
      r_err    <= 1'b0;
      r_halted <= 1'b1;
    end else begin
      unique case (r_state)
        HALT: begin
          if (run) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
          end
        end
        RUN: begin
          unique case (1'b1)
            w_do_jmp: r_pc <= w_opnd;
            w_do_rtn: begin
              if (w_empty) begin
                r_err    <= 1'b1;
                r_state  <= HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc <= w_dout;
              end
            end
            w_do_call: begin
              if (w_full) begin
                r_err    <= 1'b1;
                r_state  <= HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc <= w_opnd;
              end
            end
            w_do_stop: begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end
            default: r_pc <= w_ret;
          endcase
        end
        default: begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign halted = r_halted;
  assign err    = r_err;
endmodule

// File: tb/tb_mc14500_seq.sv
// Directed bench for mc14500_seq with a behavioural program
// memory and ICU flag decode.
module tb_mc14500_seq;
  import mc14500_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic halted;
  logic err;
  logic [11:0] mem [256];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mc14500_seq_if #(.AW(8), .IOAW(3)) bus ();

  assign bus.prog_data = mem[bus.prog_addr];
  assign bus.jmp  = (bus.i == JMP);
  assign bus.rtn  = (bus.i == RTN);
  assign bus.flg0 = (bus.i == NOPO);
  assign bus.flgf = (bus.i == NOPF);

  mc14500_seq #(
    .AW    (8),
    .IOAW  (3),
    .DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .bus    (bus),
    .halted (halted),
    .err    (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic fill();
    for (int a = 0; a < 256; a++) mem[a] = {LD, 8'(a)};
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("start_pc", 32'(bus.prog_addr), 32'h0);
    chk("start_halted", 32'(halted), 32'h0);
  endtask

  task automatic step(input string tag, input logic [7:0] e);
    @(negedge clk);
    chk(tag, 32'(bus.prog_addr), 32'(e));
  endtask

  initial begin
    // reset state and linear fetch
    fill();
    @(negedge clk);
    @(negedge clk);
    chk("rst_halted", 32'(halted), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_pc", 32'(bus.prog_addr), 32'h0);
    chk("rst_i", 32'(bus.i), 32'h0);
    chk("rst_io", 32'(bus.io_addr), 32'h0);
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("run_halted", 32'(halted), 32'h0);
    chk("run_pc0", 32'(bus.prog_addr), 32'h0);
    chk("run_i", 32'(bus.i), 32'(LD));
    step("lin1", 8'h01);
    step("lin2", 8'h02);
    step("lin3", 8'h03);
    chk("lin_io", 32'(bus.io_addr), 32'h3);

    // jump, run ignored while running
    fill();
    mem[5] = {JMP, 8'h20};
    start();
    step("j1", 8'h01);
    run = 1'b1;
    step("j2", 8'h02);
    run = 1'b0;
    step("j3", 8'h03);
    step("j4", 8'h04);
    step("j5", 8'h05);
    chk("j5_i", 32'(bus.i), 32'(JMP));
    step("j_tgt", 8'h20);
    step("j_tgt1", 8'h21);

    // call/return, then RTN on emptied stack
    fill();
    mem[3]    = {NOPO, 8'h40};
    mem[8'h40] = {RTN, 8'h00};
    mem[6]    = {RTN, 8'h00};
    start();
    step("c1", 8'h01);
    step("c2", 8'h02);
    step("c3", 8'h03);
    step("c_sub", 8'h40);
    step("c_ret", 8'h04);
    chk("c_err", 32'(err), 32'h0);
    step("c5", 8'h05);
    step("c6", 8'h06);
    @(negedge clk);
    chk("uf_err", 32'(err), 32'h1);
    chk("uf_halted", 32'(halted), 32'h1);
    chk("uf_pc", 32'(bus.prog_addr), 32'h06);

    // nested call/return order
    fill();
    mem[1]    = {NOPO, 8'h10};
    mem[8'h10] = {NOPO, 8'h20};
    mem[8'h20] = {RTN, 8'h00};
    mem[8'h11] = {RTN, 8'h00};
    start();
    step("n1", 8'h01);
    step("n2", 8'h10);
    step("n3", 8'h20);
    step("n4", 8'h11);
    step("n5", 8'h02);
    chk("n_err", 32'(err), 32'h0);

    // overflow on fifth nested call
    fill();
    mem[1]    = {NOPO, 8'h10};
    mem[8'h10] = {NOPO, 8'h20};
    mem[8'h20] = {NOPO, 8'h30};
    mem[8'h30] = {NOPO, 8'h40};
    mem[8'h40] = {NOPO, 8'h50};
    start();
    step("o1", 8'h01);
    step("o2", 8'h10);
    step("o3", 8'h20);
    step("o4", 8'h30);
    step("o5", 8'h40);
    @(negedge clk);
    chk("of_err", 32'(err), 32'h1);
    chk("of_halted", 32'(halted), 32'h1);
    chk("of_pc", 32'(bus.prog_addr), 32'h40);
    chk("of_i", 32'(bus.i), 32'h0);

    // halt via NOPF 0xFF; NOPF 0x01 is a NOP
    fill();
    mem[4] = {NOPF, 8'h01};
    mem[9] = {NOPF, 8'hFF};
    start();
    for (int k = 1; k <= 9; k++) step("h_seq", 8'(k));
    @(negedge clk);
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_i", 32'(bus.i), 32'h0);
    chk("h_io", 32'(bus.io_addr), 32'h0);
    chk("h_pc", 32'(bus.prog_addr), 32'h09);
    chk("h_err", 32'(err), 32'h0);
    step("h_hold", 8'h09);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("h_restart_pc", 32'(bus.prog_addr), 32'h0);
    chk("h_restart_hlt", 32'(halted), 32'h0);

    // PC wrap
    fill();
    start();
    repeat (255) @(negedge clk);
    chk("w_ff", 32'(bus.prog_addr), 32'hFF);
    chk("w_io", 32'(bus.io_addr), 32'h7);
    step("w_00", 8'h00);
    step("w_01", 8'h01);

    // reset mid-call, restart with empty stack
    fill();
    mem[2] = {NOPO, 8'h30};
    start();
    step("r1", 8'h01);
    step("r2", 8'h02);
    step("r3", 8'h30);
    rst = 1'b1;
    @(negedge clk);
    chk("r_halted", 32'(halted), 32'h1);
    chk("r_pc", 32'(bus.prog_addr), 32'h0);
    chk("r_err", 32'(err), 32'h0);
    rst = 1'b0;
    mem[0] = {RTN, 8'h00};
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("r_run_hlt", 32'(halted), 32'h0);
    @(negedge clk);
    chk("r_empty_err", 32'(err), 32'h1);
    chk("r_empty_hlt", 32'(halted), 32'h1);
    chk("r_empty_pc", 32'(bus.prog_addr), 32'h0);
    mem[0] = {LD, 8'h00};
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("r_run_clr_err", 32'(err), 32'h0);
    chk("r_run_clr_hlt", 32'(halted), 32'h0);
    step("r_run_pc1", 8'h01);

    // rst wins over run
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    chk("rr_halted", 32'(halted), 32'h1);
    chk("rr_pc", 32'(bus.prog_addr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
